run_ctrl: RTL and testbench

Run sequencer and data-memory arbiter for the 9-bit single-cycle core. The host loads data memory, pulses a start, and the block holds then releases the core's Reset. It counts cycles until the core raises Done (or a timeout expires), then hands memory back to the host for readback. It sits above the core top level: it drives the core's Reset and owns the host-side data-memory port and the ownership select.

---
 rtl/run_ctrl_pkg.sv | 19 +
 rtl/run_ctrl_hostport.sv | 80 ++++++++
 rtl/run_ctrl.sv | 167 ++++++++++++++++
 tb/tb_run_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/run_ctrl_pkg.sv
// Shared types and default sizes for the run sequencer / data-memory arbiter.
// The state enum is the only type shared between the top and its tests of state.
package run_ctrl_pkg;

  localparam int          DEF_AW         = 8;
  localparam int          DEF_DW         = 8;
  localparam int          DEF_CW         = 16;
  localparam logic [15:0] DEF_MAX_CYCLES = 16'hFFFF;
  localparam int          DEF_RST_CYC    = 2;

  typedef enum logic [2:0] {
    IDLE,
    CORE_RST,
    RUN,
    FINISH,
    TOUT
  } run_state_t;

endpackage

// File: rtl/run_ctrl_hostport.sv
// Host-side data-memory port: write-over-read arbitration during host phase and
// the registered read-data path with its one-cycle valid pulse.
module run_ctrl_hostport #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          i_host_phase,
  input  logic          i_wr_valid,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [DW-1:0] i_wr_data,
  input  logic          i_rd_valid,
  input  logic [AW-1:0] i_rd_addr,
  input  logic [DW-1:0] i_mem_rdata,
  output logic          o_wr_ready,
  output logic          o_rd_ready,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  output logic          o_mem_we,
  output logic          o_mem_re,
  output logic [DW-1:0] o_rd_data,
  output logic          o_rd_data_valid
);

  logic          w_open;
  logic          w_wr_ready;
  logic          w_rd_ready;
  logic          w_we;
  logic          w_re;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;
  logic [DW-1:0] r_rd_data;
  logic          r_rd_data_valid;

  // Requests presented while Reset is high are refused so nothing reaches memory.
  assign w_open = i_host_phase & ~Reset;

  // NOTE: every output of this block is given a default before any condition,
  // so no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    w_wr_ready = w_open;
    w_rd_ready = w_open & ~i_wr_valid;
    w_we       = i_wr_valid & w_wr_ready;
    w_re       = i_rd_valid & w_rd_ready;
    w_addr     = '0;
    w_wdata    = '0;
    if (w_we) begin
      w_addr  = i_wr_addr;
      w_wdata = i_wr_data;
    end else if (w_re) begin
      w_addr = i_rd_addr;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples its inputs from before the edge; the reset is synchronous and clears
  // the read-data register too, because the host may observe it after reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_rd_data       <= '0;
      r_rd_data_valid <= 1'b0;
    end else begin
      r_rd_data_valid <= w_re;
      if (w_re) begin
        r_rd_data <= i_mem_rdata;
      end
    end
  end

  assign o_wr_ready      = w_wr_ready;
  assign o_rd_ready      = w_rd_ready;
  assign o_mem_we        = w_we;
  assign o_mem_re        = w_re;
  assign o_mem_addr      = w_addr;
  assign o_mem_wdata     = w_wdata;
  assign o_rd_data       = r_rd_data;
  assign o_rd_data_valid = r_rd_data_valid;

endmodule

// File: rtl/run_ctrl.sv
// Run sequencer for the 9-bit core: holds core Reset after a start, counts RUN
// cycles until core_done or the cycle limit, and returns data memory to the host.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int          AW         = DEF_AW,
  parameter int          DW         = DEF_DW,
  parameter int          CW         = DEF_CW,
  parameter logic [CW-1:0] MAX_CYCLES = DEF_MAX_CYCLES,
  parameter int          RST_CYC    = DEF_RST_CYC
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          host_start,
  input  logic          host_wr_valid,
  input  logic [AW-1:0] host_wr_addr,
  input  logic [DW-1:0] host_wr_data,
  output logic          host_wr_ready,
  input  logic          host_rd_valid,
  input  logic [AW-1:0] host_rd_addr,
  output logic          host_rd_ready,
  output logic [DW-1:0] host_rd_data,
  output logic          host_rd_data_valid,
  output logic          core_reset,
  input  logic          core_done,
  output logic          mem_sel,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  output logic          mem_re,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic [CW-1:0] cycle_count
);

  localparam int            RCW      = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam logic [RCW-1:0] RST_LOAD = RCW'(RST_CYC - 1);
  localparam logic [CW-1:0]  LIMIT_M1 = MAX_CYCLES - 1'b1;

  run_state_t     r_state;
  run_state_t     w_next;
  logic [RCW-1:0] r_rst_cnt;
  logic [CW-1:0]  r_cycle_count;
  logic           r_done;
  logic           r_timeout;

  logic w_host_phase;
  logic w_start;
  logic w_run_done;
  logic w_run_tout;
  logic w_core_reset;
  logic w_mem_sel;
  logic w_busy;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_host_phase = 1'b0;
    w_start      = 1'b0;
    w_run_done   = 1'b0;
    w_run_tout   = 1'b0;
    w_core_reset = 1'b1;
    w_mem_sel    = 1'b0;
    w_busy       = 1'b0;
    case (r_state)
      IDLE, FINISH, TOUT: begin
        w_host_phase = 1'b1;
        if (host_start) begin
          w_start = 1'b1;
          w_next  = CORE_RST;
        end
      end
      CORE_RST: begin
        w_mem_sel = 1'b1;
        w_busy    = 1'b1;
        if (r_rst_cnt == '0) begin
          w_next = RUN;
        end
      end
      RUN: begin
        w_core_reset = 1'b0;
        w_mem_sel    = 1'b1;
        w_busy       = 1'b1;
        // core_done is tested first so it wins over the limit in the same cycle.
        if (core_done) begin
          w_run_done = 1'b1;
          w_next     = FINISH;
        end else if (r_cycle_count == LIMIT_M1) begin
          w_run_tout = 1'b1;
          w_next     = TOUT;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // The counter keeps counting on the timeout cycle, so it ends at MAX_CYCLES;
  // the core_done cycle is not counted.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_rst_cnt     <= '0;
      r_cycle_count <= '0;
      r_done        <= 1'b0;
      r_timeout     <= 1'b0;
    end else if (w_start) begin
      r_rst_cnt     <= RST_LOAD;
      r_cycle_count <= '0;
      r_done        <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      if (r_state == CORE_RST && r_rst_cnt != '0) begin
        r_rst_cnt <= r_rst_cnt - 1'b1;
      end
      if (r_state == RUN && !core_done) begin
        r_cycle_count <= r_cycle_count + 1'b1;
      end
      if (w_run_done) begin
        r_done <= 1'b1;
      end
      if (w_run_tout) begin
        r_timeout <= 1'b1;
      end
    end
  end

  run_ctrl_hostport #(
    .AW (AW),
    .DW (DW)
  ) u_hostport (
    .Clk             (Clk),
    .Reset           (Reset),
    .i_host_phase    (w_host_phase),
    .i_wr_valid      (host_wr_valid),
    .i_wr_addr       (host_wr_addr),
    .i_wr_data       (host_wr_data),
    .i_rd_valid      (host_rd_valid),
    .i_rd_addr       (host_rd_addr),
    .i_mem_rdata     (mem_rdata),
    .o_wr_ready      (host_wr_ready),
    .o_rd_ready      (host_rd_ready),
    .o_mem_addr      (mem_addr),
    .o_mem_wdata     (mem_wdata),
    .o_mem_we        (mem_we),
    .o_mem_re        (mem_re),
    .o_rd_data       (host_rd_data),
    .o_rd_data_valid (host_rd_data_valid)
  );

  assign core_reset  = w_core_reset;
  assign mem_sel     = w_mem_sel;
  assign busy        = w_busy;
  assign done        = r_done;
  assign timeout     = r_timeout;
  assign cycle_count = r_cycle_count;

endmodule

// File: tb/tb_run_ctrl.sv
// Randomized bench for run_ctrl: a behavioural memory plus a scoreboard of
// expected contents, and run outcomes predicted from the done delay alone.
module tb_run_ctrl;

  localparam int AW   = 8;
  localparam int DW   = 8;
  localparam int CW   = 16;
  localparam int MAXC = 100;
  localparam int RSTC = 2;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          host_start;
  logic          host_wr_valid;
  logic [AW-1:0] host_wr_addr;
  logic [DW-1:0] host_wr_data;
  logic          host_wr_ready;
  logic          host_rd_valid;
  logic [AW-1:0] host_rd_addr;
  logic          host_rd_ready;
  logic [DW-1:0] host_rd_data;
  logic          host_rd_data_valid;
  logic          core_reset;
  logic          core_done;
  logic          mem_sel;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic          mem_re;
  logic [DW-1:0] mem_rdata;
  logic          busy;
  logic          done;
  logic          timeout;
  logic [CW-1:0] cycle_count;

  logic [DW-1:0] phys    [0:255];
  logic [DW-1:0] exp_mem [0:255];

  int n_total = 0;
  int n_bad   = 0;

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (mem_we) phys[mem_addr] <= mem_wdata;
  end
  assign mem_rdata = phys[mem_addr];

  run_ctrl #(
    .AW         (AW),
    .DW         (DW),
    .CW         (CW),
    .MAX_CYCLES (16'd100),
    .RST_CYC    (RSTC)
  ) dut (
    .Clk                (Clk),
    .Reset              (Reset),
    .host_start         (host_start),
    .host_wr_valid      (host_wr_valid),
    .host_wr_addr       (host_wr_addr),
    .host_wr_data       (host_wr_data),
    .host_wr_ready      (host_wr_ready),
    .host_rd_valid      (host_rd_valid),
    .host_rd_addr       (host_rd_addr),
    .host_rd_ready      (host_rd_ready),
    .host_rd_data       (host_rd_data),
    .host_rd_data_valid (host_rd_data_valid),
    .core_reset         (core_reset),
    .core_done          (core_done),
    .mem_sel            (mem_sel),
    .mem_addr           (mem_addr),
    .mem_wdata          (mem_wdata),
    .mem_we             (mem_we),
    .mem_re             (mem_re),
    .mem_rdata          (mem_rdata),
    .busy               (busy),
    .done               (done),
    .timeout            (timeout),
    .cycle_count        (cycle_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_inputs();
    host_start    = 1'b0;
    host_wr_valid = 1'b0;
    host_rd_valid = 1'b0;
    core_done     = 1'b0;
  endtask

  task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    host_wr_valid = 1'b1;
    host_wr_addr  = a;
    host_wr_data  = d;
    #1;
    check("wr_ready", host_wr_ready, 1);
    check("wr_mem_we", mem_we, 1);
    check("wr_mem_addr", mem_addr, a);
    tick();
    host_wr_valid = 1'b0;
    exp_mem[a] = d;
  endtask

  task automatic host_read(input logic [AW-1:0] a);
    host_rd_valid = 1'b1;
    host_rd_addr  = a;
    #1;
    check("rd_ready", host_rd_ready, 1);
    check("rd_mem_re", mem_re, 1);
    tick();
    host_rd_valid = 1'b0;
    check("rd_data_valid", host_rd_data_valid, 1);
    check("rd_data", host_rd_data, exp_mem[a]);
  endtask

  // d: RUN cycle index at which core_done is raised (>= MAXC means never).
  // abort_at: RUN cycle index at which Reset is pulsed (-1 means never).
  task automatic do_run(input int d, input int abort_at, input bit wr_with_start);
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    int            exp_cnt;
    bit            exp_done;
    wa = 8'($urandom);
    wd = 8'($urandom);
    host_start = 1'b1;
    if (wr_with_start) begin
      host_wr_valid = 1'b1;
      host_wr_addr  = wa;
      host_wr_data  = wd;
      #1;
      check("start_wr_we", mem_we, 1);
    end
    tick();
    clear_inputs();
    if (wr_with_start) exp_mem[wa] = wd;

    for (int i = 0; i < RSTC; i++) begin
      core_done     = 1'($urandom_range(0, 1));
      host_start    = 1'($urandom_range(0, 1));
      host_wr_valid = 1'($urandom_range(0, 1));
      host_rd_valid = 1'($urandom_range(0, 1));
      #1;
      check("crst_core_reset", core_reset, 1);
      check("crst_busy", busy, 1);
      check("crst_mem_sel", mem_sel, 1);
      check("crst_mem_we", mem_we, 0);
      check("crst_wr_ready", host_wr_ready, 0);
      check("crst_count", cycle_count, 0);
      tick();
    end
    clear_inputs();

    for (int k = 0; k < MAXC; k++) begin
      core_done     = (k == d);
      host_start    = ($urandom_range(0, 3) == 0);
      host_wr_valid = 1'($urandom_range(0, 1));
      host_rd_valid = 1'($urandom_range(0, 1));
      host_wr_addr  = 8'($urandom);
      host_rd_addr  = 8'($urandom);
      if (k == abort_at) Reset = 1'b1;
      #1;
      check("run_core_reset", core_reset, 0);
      check("run_count", cycle_count, k);
      check("run_mem_sel", mem_sel, 1);
      check("run_mem_we", mem_we, 0);
      check("run_mem_re", mem_re, 0);
      check("run_wr_ready", host_wr_ready, 0);
      check("run_rd_ready", host_rd_ready, 0);
      check("run_rd_dvalid", host_rd_data_valid, 0);
      tick();
      if (k == abort_at) begin
        Reset = 1'b0;
        clear_inputs();
        check("abort_core_reset", core_reset, 1);
        check("abort_mem_sel", mem_sel, 0);
        check("abort_busy", busy, 0);
        check("abort_count", cycle_count, 0);
        check("abort_done", done, 0);
        check("abort_timeout", timeout, 0);
        return;
      end
      if (k == d) break;
    end
    clear_inputs();

    exp_done = (d < MAXC);
    exp_cnt  = exp_done ? d : MAXC;
    check("end_done", done, 32'(exp_done));
    check("end_timeout", timeout, 32'(!exp_done));
    check("end_count", cycle_count, exp_cnt);
    check("end_busy", busy, 0);
    check("end_mem_sel", mem_sel, 0);
    check("end_core_reset", core_reset, 1);
    host_read(8'($urandom));
    check("hold_count", cycle_count, exp_cnt);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=expired exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] a;
    logic [DW-1:0] keep;
    Reset = 1'b1;
    clear_inputs();
    host_wr_addr = '0;
    host_wr_data = '0;
    host_rd_addr = '0;
    tick();
    tick();
    Reset = 1'b0;
    #1;
    check("rst_core_reset", core_reset, 1);
    check("rst_mem_sel", mem_sel, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_timeout", timeout, 0);
    check("rst_count", cycle_count, 0);
    check("rst_rd_data", host_rd_data, 0);
    check("rst_rd_dvalid", host_rd_data_valid, 0);

    host_write(8'h10, 8'hA5);
    check("idle_core_reset", core_reset, 1);
    host_read(8'h10);
    check("idle_core_reset2", core_reset, 1);
    tick();
    check("rd_dvalid_pulse", host_rd_data_valid, 0);

    for (int i = 0; i < 256; i++) host_write(8'(i), 8'($urandom));

    host_wr_valid = 1'b1; host_wr_addr = 8'h03; host_wr_data = 8'h5C;
    host_rd_valid = 1'b1; host_rd_addr = 8'h03;
    #1;
    check("both_wr_ready", host_wr_ready, 1);
    check("both_rd_ready", host_rd_ready, 0);
    check("both_mem_we", mem_we, 1);
    check("both_mem_re", mem_re, 0);
    tick();
    exp_mem[3] = 8'h5C;
    host_wr_valid = 1'b0;
    #1;
    check("both_no_dvalid", host_rd_data_valid, 0);
    check("both_rd_ready2", host_rd_ready, 1);
    tick();
    host_rd_valid = 1'b0;
    check("both_rd_dvalid", host_rd_data_valid, 1);
    check("both_rd_data", host_rd_data, 8'h5C);

    do_run(37, -1, 1);
    do_run(500, -1, 0);
    for (int i = 0; i < 3; i++) host_read(8'($urandom));
    do_run(MAXC - 1, -1, 0);
    do_run(MAXC - 2, -1, 1);
    do_run(0, -1, 0);
    do_run(60, 20, 0);
    do_run(45, -1, 0);

    // A write presented during a reset cycle must not reach memory.
    a    = 8'($urandom);
    keep = exp_mem[a];
    Reset = 1'b1;
    host_wr_valid = 1'b1; host_wr_addr = a; host_wr_data = ~keep;
    tick();
    Reset = 1'b0;
    host_wr_valid = 1'b0;
    check("rstdrop_dvalid", host_rd_data_valid, 0);
    host_read(a);

    for (int r = 0; r < 8; r++) begin
      host_write(8'($urandom), 8'($urandom));
      do_run($urandom_range(0, 120), -1, 1'($urandom_range(0, 1)));
      host_read(8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
